// File: rtl/stepdown_softstop_seq.sv
// Soft-stop sequencer: holds the reference code while running, ramps it to zero
// on enable withdrawal, then disables the drivers, settles and tristates the stage.
module stepdown_softstop_seq #(
    parameter int CODE_W    = 8,
    parameter int STEP_DIV  = 16,
    parameter int DONE_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              ss_done,
    input  logic              fault,
    input  logic [CODE_W-1:0] start_code,
    output logic [CODE_W-1:0] ref_code,
    output logic              drv_en,
    output logic              tstate_o,
    output logic              busy,
    output logic              off_done,
    input  logic              CELV,
    input  logic              CELG,
    input  logic              CELSUB
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RUN  = 3'd1;
    localparam logic [2:0] RAMP = 3'd2;
    localparam logic [2:0] HOLD = 3'd3;
    localparam logic [2:0] OFF  = 3'd4;

    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int HW = $clog2(DONE_HOLD + 1);
    localparam logic [PW-1:0] PS_LAST = PW'(STEP_DIV - 1);
    localparam logic [HW-1:0] HD_LAST = HW'(DONE_HOLD - 1);

    logic [2:0]    state;
    logic [PW-1:0] presc;
    logic [HW-1:0] hcnt;
    logic          active;
    logic          go_off;

    // Supply pins exist only for the physical netlist.
    logic unused_supply;
    assign unused_supply = CELV ^ CELG ^ CELSUB;

    // Fault wins over everything while the stage is powered; HOLD expiry shares the same exit.
    assign active = (state == RUN) || (state == RAMP) || (state == HOLD);
    assign go_off = active && (fault || ((state == HOLD) && (hcnt == HD_LAST)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ref_code <= '0;
            drv_en   <= 1'b0;
            tstate_o <= 1'b1;
            busy     <= 1'b0;
            off_done <= 1'b0;
            presc    <= '0;
            hcnt     <= '0;
        end else begin
            off_done <= 1'b0;
            if (go_off) begin
                state    <= OFF;
                ref_code <= '0;
                drv_en   <= 1'b0;
                tstate_o <= 1'b1;
                busy     <= 1'b0;
                off_done <= 1'b1;
                presc    <= '0;
                hcnt     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (en && ss_done && !fault) begin
                            state    <= RUN;
                            ref_code <= start_code;
                            drv_en   <= 1'b1;
                            tstate_o <= 1'b0;
                            busy     <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (!en) begin
                            state <= RAMP;
                            presc <= '0;
                        end
                    end
                    RAMP: begin
                        // Re-enable resumes from the partially ramped code, no reload.
                        if (en) begin
                            state <= RUN;
                            presc <= '0;
                        end else if (presc == PS_LAST) begin
                            presc <= '0;
                            if (ref_code != '0) begin
                                ref_code <= ref_code - 1'b1;
                            end else begin
                                state  <= HOLD;
                                drv_en <= 1'b0;
                                hcnt   <= '0;
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    HOLD: hcnt <= hcnt + 1'b1;
                    OFF:  state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stepdown_softstop_seq.sv
// Bench for stepdown_softstop_seq: expected output timelines are derived from the
// documented cycle timing, queued per cycle, and compared as the DUT runs.
module tb_stepdown_softstop_seq;

    localparam int CW = 8;
    localparam int S  = 4;
    localparam int H  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          ss_done = 1'b0;
    logic          fault = 1'b0;
    logic [CW-1:0] start_code = '0;
    logic [CW-1:0] ref_code;
    logic          drv_en, tstate_o, busy, off_done;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        logic [11:0] v;
    } exp_t;
    exp_t sb[$];

    stepdown_softstop_seq #(.CODE_W(CW), .STEP_DIV(S), .DONE_HOLD(H)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ss_done(ss_done), .fault(fault),
        .start_code(start_code), .ref_code(ref_code), .drv_en(drv_en),
        .tstate_o(tstate_o), .busy(busy), .off_done(off_done),
        .CELV(1'b1), .CELG(1'b0), .CELSUB(1'b0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // {ref_code, drv_en, tstate_o, busy, off_done}
    function automatic logic [11:0] pk(input logic [7:0] r, input logic d, input logic t,
                                       input logic b, input logic o);
        return {r, d, t, b, o};
    endfunction

    function automatic logic [11:0] obs();
        return {ref_code, drv_en, tstate_o, busy, off_done};
    endfunction

    task automatic push(input int c, input logic [11:0] v);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        sb.push_back(e);
    endtask

    // Stop sequence from RAMP entry cycle r with code n: (n+1)*S ramp cycles,
    // H hold cycles, one OFF cycle, then IDLE.
    task automatic push_stop(input int r, input int n);
        int o;
        for (int k = 0; k < (n + 1) * S; k++) push(r + k, pk(8'(n - k / S), 1, 0, 1, 0));
        for (int h = 0; h < H; h++) push(r + (n + 1) * S + h, pk(0, 0, 0, 1, 0));
        o = r + (n + 1) * S + H;
        push(o, pk(0, 0, 1, 0, 1));
        push(o + 1, pk(0, 0, 1, 0, 0));
    endtask

    task automatic test_reset();
        exp_t e;
        for (int c = 1; c <= 13; c++) push(c, pk(0, 0, 1, 0, 0));
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                n_chk++;
                if (obs() !== e.v) begin
                    n_fail++;
                    $display("FAIL reset cyc=%0d got=%h want=%h", cyc, obs(), e.v);
                end
            end
            if (cyc == 3) begin
                rst_n = 1'b1;
                en = 1'b1;
            end
        end
        en = 1'b0;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL reset_leftover got=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_nominal();
        exp_t e;
        int t, tt;
        @(negedge clk);
        start_code = 8'd3; en = 1'b1; ss_done = 1'b1;
        t = cyc; tt = t + 4;
        for (int c = t + 1; c <= tt; c++) push(c, pk(3, 1, 0, 1, 0));
        push_stop(tt + 1, 3);
        push(tt + 23, pk(0, 0, 1, 0, 0));
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                n_chk++;
                if (obs() !== e.v) begin
                    n_fail++;
                    $display("FAIL nominal cyc=%0d got=%h want=%h", cyc, obs(), e.v);
                end
            end
            if (cyc == t + 2) ss_done = 1'b0;
            if (cyc == tt) en = 1'b0;
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL nominal_leftover got=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_fault();
        exp_t e;
        int t, r;
        @(negedge clk);
        start_code = 8'd200; en = 1'b1; ss_done = 1'b1;
        t = cyc; r = t + 2;
        push(t + 1, pk(200, 1, 0, 1, 0));
        for (int k = 0; k <= 201; k++) push(r + k, pk(8'(200 - k / S), 1, 0, 1, 0));
        push(r + 202, pk(0, 0, 1, 0, 1));
        for (int c = r + 203; c <= r + 206; c++) push(c, pk(0, 0, 1, 0, 0));
        for (int i = 0; i < r + 206 - t; i++) begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                n_chk++;
                if (obs() !== e.v) begin
                    n_fail++;
                    $display("FAIL fault cyc=%0d got=%h want=%h", cyc, obs(), e.v);
                end
            end
            if (cyc == t + 1) en = 1'b0;
            if (cyc == r + 201) fault = 1'b1;
        end
        fault = 1'b0;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL fault_leftover got=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_abort();
        exp_t e;
        int t, r, r2;
        @(negedge clk);
        start_code = 8'd10; en = 1'b1; ss_done = 1'b1;
        t = cyc; r = t + 2; r2 = r + 21;
        push(t + 1, pk(10, 1, 0, 1, 0));
        for (int k = 0; k <= 16; k++) push(r + k, pk(8'(10 - k / S), 1, 0, 1, 0));
        for (int c = r + 17; c <= r + 20; c++) push(c, pk(6, 1, 0, 1, 0));
        push_stop(r2, 6);
        for (int i = 0; i < r2 + 7 * S + H + 1 - t; i++) begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                n_chk++;
                if (obs() !== e.v) begin
                    n_fail++;
                    $display("FAIL abort cyc=%0d got=%h want=%h", cyc, obs(), e.v);
                end
            end
            if (cyc == t + 1) en = 1'b0;
            if (cyc == r + 16) en = 1'b1;
            if (cyc == r + 20) en = 1'b0;
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL abort_leftover got=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_zero_code();
        exp_t e;
        int t;
        @(negedge clk);
        start_code = 8'd0; en = 1'b1; ss_done = 1'b1;
        t = cyc;
        push(t + 1, pk(0, 1, 0, 1, 0));
        push_stop(t + 2, 0);
        for (int i = 0; i < 1 + S + H + 2; i++) begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                n_chk++;
                if (obs() !== e.v) begin
                    n_fail++;
                    $display("FAIL zero_code cyc=%0d got=%h want=%h", cyc, obs(), e.v);
                end
            end
            if (cyc == t + 1) en = 1'b0;
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL zero_code_leftover got=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        int t, r;
        @(negedge clk);
        start_code = 8'd2; en = 1'b1; ss_done = 1'b1;
        t = cyc; r = t + 2;
        push(t + 1, pk(2, 1, 0, 1, 0));
        for (int k = 0; k < 3 * S; k++) push(r + k, pk(8'(2 - k / S), 1, 0, 1, 0));
        push(r + 12, pk(0, 0, 0, 1, 0));
        push(r + 13, pk(0, 0, 0, 1, 0));
        for (int i = 0; i < r + 13 - t; i++) begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                n_chk++;
                if (obs() !== e.v) begin
                    n_fail++;
                    $display("FAIL async_reset cyc=%0d got=%h want=%h", cyc, obs(), e.v);
                end
            end
            if (cyc == t + 1) en = 1'b0;
        end
        #3 rst_n = 1'b0;
        #1;
        n_chk++;
        if (obs() !== pk(0, 0, 1, 0, 0)) begin
            n_fail++;
            $display("FAIL async_reset_immediate got=%h want=%h", obs(), pk(0, 0, 1, 0, 0));
        end
        for (int c = r + 14; c <= r + 16; c++) push(c, pk(0, 0, 1, 0, 0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                n_chk++;
                if (obs() !== e.v) begin
                    n_fail++;
                    $display("FAIL async_reset_hold cyc=%0d got=%h want=%h", cyc, obs(), e.v);
                end
            end
        end
        rst_n = 1'b1;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL async_reset_leftover got=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_fault();
        test_abort();
        test_zero_code();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/stepdown_softstop_seq.md
# stepdown_softstop_seq

Soft-stop sequencer for the step-down converter; the shutdown-side counterpart of the soft-start enable path. Once soft-start reports the output is up, this block holds the reference code. When the enable request is withdrawn, it ramps the reference code down to zero in fixed-time steps. It then disables the power-stage drivers, waits a settle interval, and tristates the stage. A fault bypasses the ramp and forces the stage off immediately.

## Interface
Parameters:
- CODE_W, 8, width of the reference DAC code
- STEP_DIV, 16, clocks per ramp step (≥2)
- DONE_HOLD, 4, clocks between driver disable and tristate (≥1)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  converter enable request, synchronous to clk
- ss_done  in  1  soft-start complete, level
- fault  in  1  fault shutdown request, level
- start_code  in  CODE_W  reference code loaded at run start
- ref_code  out  CODE_W  reference DAC code
- drv_en  out  1  power-stage driver enable
- tstate_o  out  1  power-stage tristate control, 1 = hi-Z
- busy  out  1  high in states RUN, RAMP and HOLD
- off_done  out  1  one-cycle pulse when shutdown completes
- CELV, CELG, CELSUB  in  1 each  supply, ground and substrate; no logic function

## Operation
- All outputs are registered.
- Reset values: ref_code=0, drv_en=0, tstate_o=1, busy=0, off_done=0, state=IDLE, all counters 0.
- States and transitions:
  - IDLE: outputs at their reset values.
    - en & ss_done & !fault → RUN. On entry, ref_code←start_code, drv_en←1, tstate_o←0.
  - RUN: ref_code is held.
    - fault → OFF.
    - !en → RAMP. On entry, the prescaler is cleared.
  - RAMP: the prescaler counts 0..STEP_DIV-1 and wraps. A tick is the cycle in which prescaler==STEP_DIV-1.
    - On a tick with ref_code>0: ref_code←ref_code-1.
    - On a tick with ref_code==0: → HOLD, and drv_en←0.
    - en reasserted (and no fault) → RUN. ref_code is kept at its current value (no reload) and the prescaler is cleared.
    - fault → OFF.
  - HOLD: the hold counter counts DONE_HOLD cycles, then → OFF.
    - fault → OFF immediately.
    - en is ignored.
  - OFF: lasts exactly one cycle.
    - ref_code=0, drv_en=0, tstate_o=1, off_done=1.
    - Next state is IDLE.
- Priority: fault > en. fault has no effect in IDLE or OFF.
- Arithmetic: ref_code decrements saturate at 0; there is no wrap below zero.
- start_code=0: the RAMP phase is a single tick period before moving to HOLD.
- Removing ss_done after RUN is entered has no effect.
- Asynchronous reset mid-operation: all outputs return to their reset values immediately, including tstate_o=1. No off_done pulse is generated.

## Timing
- IDLE→RUN: outputs update one clock after en & ss_done are sampled high.
- RAMP entry: one clock after en is sampled low.
- Ramp length: a start code of N spends (N+1)·STEP_DIV cycles in RAMP.
  - ref_code updates on the clock edge following each tick cycle.
  - Step k (k=1..N) takes effect k·STEP_DIV cycles after RAMP entry.
- drv_en falls on the clock edge at which HOLD is entered.
- HOLD lasts DONE_HOLD cycles. tstate_o rises and off_done pulses on OFF entry.
- busy falls on the same edge that off_done rises.
- Fault response: one clock from fault sampled high to drv_en=0, tstate_o=1, ref_code=0.

## Test plan
- Reset/idle: rst_n low for 3 clocks, then en=1 with ss_done=0 for 10 clocks → ref_code=0, drv_en=0, tstate_o=1, busy=0 throughout.
- Nominal stop (STEP_DIV=4, DONE_HOLD=4, start_code=3):
  - Stimulus: ss_done=1 and en=1 → ref_code=3, drv_en=1. en drops at cycle T.
  - Required: RAMP entered at T+1; ref_code becomes 2/1/0 at T+5/T+9/T+13.
  - Required: HOLD at T+17 with drv_en=0; off_done single pulse and tstate_o=1 at T+21; IDLE at T+22.
- Fault mid-ramp: start_code=200, en drops, fault=1 when ref_code=150 → next clock ref_code=0, drv_en=0, tstate_o=1, off_done=1, and no further decrements.
- Ramp abort: start_code=10, en drops, en reasserted when ref_code=6 → RUN with ref_code held at 6; a second en drop ramps from 6, reaching HOLD after 7·STEP_DIV cycles.
- Zero code and saturation: start_code=0, en drops → HOLD after exactly STEP_DIV cycles in RAMP; ref_code is never 255.
- Async reset in HOLD: rst_n asserted mid-HOLD, not aligned to clk → tstate_o=1 and busy=0 before the next edge; no off_done pulse.
